// File: rtl/video_level_decoder.sv
// video_level_decoder: 2-bit level video receiver (SYNC=0..WHITE=3) rebuilding hsync/vsync, pixel x/y/level and lock; ports clk, reset, pix_en, video_in in, pixel_valid/x/y/level, line_start, frame_start, locked, sync_error out; VIDEO_DECODER_STATS_EN adds frame_count/last_lines
module video_level_decoder #(
  parameter int H_DISPLAY = 256,
  parameter int H_BACK    = 60,
  parameter int V_DISPLAY = 240,
  parameter int V_BACK    = 18,
  parameter int HSYNC_MIN = 16,
  parameter int HSYNC_MAX = 40,
  parameter int VSYNC_MIN = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic [1:0] video_in,
  output logic       pixel_valid,
  output logic [8:0] pixel_x,
  output logic [8:0] pixel_y,
  output logic [1:0] pixel_level,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_error
`ifdef VIDEO_DECODER_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [9:0]  last_lines
`endif
);
  localparam logic [11:0] HS_MIN = 12'(HSYNC_MIN);
  localparam logic [11:0] HS_MAX = 12'(HSYNC_MAX);
  localparam logic [11:0] VS_MIN = 12'(VSYNC_MIN);
  localparam logic [9:0]  HB     = 10'(H_BACK);
  localparam logic [9:0]  HE     = 10'(H_BACK + H_DISPLAY);
  localparam logic [9:0]  VB1    = 10'(V_BACK + 1);
  localparam logic [9:0]  VD     = 10'(V_DISPLAY);
  typedef enum logic [1:0] {SEARCH, TOP, ACTIVE} state_t;
  state_t      state, state_n;
  logic [11:0] run_cnt, run_n;
  logic [9:0]  h_cnt, h_n, line_cnt, line_n, act_cnt, act_n;
  logic        is_sync, run_end, hs, vs, bad, frame_ok, frame_bad, pix;
  always_comb begin
    is_sync   = video_in == 2'd0;
    run_end   = !is_sync && run_cnt != 12'd0;
    hs        = run_end && run_cnt >= HS_MIN && run_cnt <= HS_MAX;
    vs        = run_end && run_cnt >= VS_MIN;
    bad       = run_end && !hs && !vs;
    run_n     = is_sync ? (run_cnt == '1 ? run_cnt : run_cnt + 12'd1) : 12'd0;
    h_n       = hs ? 10'd0 : (h_cnt == '1 ? h_cnt : h_cnt + 10'd1);
    line_n    = vs ? 10'd0 : (hs && line_cnt != '1) ? line_cnt + 10'd1 : line_cnt;
    frame_ok  = vs && state == ACTIVE && act_cnt == VD;
    frame_bad = vs && state == ACTIVE && act_cnt != VD;
    state_n   = state;
    act_n     = act_cnt;
    if (bad) begin
      state_n = SEARCH;
      act_n   = 10'd0;
    end else if (vs) begin
      state_n = TOP;
      act_n   = 10'd0;
    end else if (hs && state == TOP && line_n == VB1) begin
      state_n = ACTIVE;
      act_n   = 10'd1;
    end else if (hs && state == ACTIVE) begin
      act_n   = act_cnt == '1 ? act_cnt : act_cnt + 10'd1;
    end
    pix = state_n == ACTIVE && !is_sync && h_n >= HB && h_n < HE && act_n <= VD;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEARCH;
      run_cnt     <= '0;
      h_cnt       <= '0;
      line_cnt    <= '0;
      act_cnt     <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_level <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_error  <= 1'b0;
`ifdef VIDEO_DECODER_STATS_EN
      frame_count <= '0;
      last_lines  <= '0;
`endif
    end else begin
      pixel_valid <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      sync_error  <= 1'b0;
      if (pix_en) begin
        state       <= state_n;
        run_cnt     <= run_n;
        h_cnt       <= h_n;
        line_cnt    <= line_n;
        act_cnt     <= act_n;
        pixel_valid <= pix;
        line_start  <= hs;
        frame_start <= vs;
        sync_error  <= bad || frame_bad;
        if (pix) begin
          pixel_x     <= 9'(h_n - HB);
          pixel_y     <= 9'(act_n - 10'd1);
          pixel_level <= video_in;
        end
        if (bad || frame_bad) locked <= 1'b0;
        else if (frame_ok) locked <= 1'b1;
`ifdef VIDEO_DECODER_STATS_EN
        if (vs) begin
          frame_count <= frame_count + 16'd1;
          last_lines  <= act_cnt;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_video_level_decoder.sv
// tb_video_level_decoder: randomized frame generator with a structural expectation model for video_level_decoder
module tb_video_level_decoder;
  localparam int H_DISPLAY = 20;
  localparam int H_BACK    = 6;
  localparam int V_DISPLAY = 10;
  localparam int V_BACK    = 3;
  localparam int HSYNC_MIN = 4;
  localparam int HSYNC_MAX = 8;
  localparam int VSYNC_MIN = 30;
  localparam int LINE_NS   = 30;
  localparam int FULL      = V_BACK + V_DISPLAY;
  logic       clk = 1'b0;
  logic       reset, pix_en;
  logic [1:0] video_in;
  logic       pixel_valid, line_start, frame_start, locked, sync_error;
  logic [8:0] pixel_x, pixel_y;
  logic [1:0] pixel_level;
`ifdef VIDEO_DECODER_STATS_EN
  logic [15:0] frame_count;
  logic [9:0]  last_lines;
`endif
  int errors = 0, checks = 0;
  int ls_cnt = 0, fs_cnt = 0, se_cnt = 0;
  int ls_exp = 0, fs_exp = 0, se_exp = 0, fc_exp = 0, ll_exp = 0, lines = 0;
  bit synced = 1'b0, lock_exp = 1'b0;
  logic [19:0] exp_q[$];
  video_level_decoder #(
    .H_DISPLAY(H_DISPLAY), .H_BACK(H_BACK), .V_DISPLAY(V_DISPLAY), .V_BACK(V_BACK),
    .HSYNC_MIN(HSYNC_MIN), .HSYNC_MAX(HSYNC_MAX), .VSYNC_MIN(VSYNC_MIN)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .video_in(video_in),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_level(pixel_level),
    .line_start(line_start), .frame_start(frame_start), .locked(locked), .sync_error(sync_error)
`ifdef VIDEO_DECODER_STATS_EN
    , .frame_count(frame_count), .last_lines(last_lines)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    ls_cnt += int'(line_start);
    fs_cnt += int'(frame_start);
    se_cnt += int'(sync_error);
    if (line_start || frame_start) chk("ls_fs_exclusive", int'(line_start & frame_start), 0);
    if (pixel_valid) begin
      chk("pixel_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("pixel_x_y_level", int'({pixel_x, pixel_y, pixel_level}), int'(exp_q.pop_front()));
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_en = 1'b0;
      video_in = 2'($urandom);
    end
  endtask
  task automatic put(input logic [1:0] lvl);
    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    @(negedge clk);
    pix_en = 1'b1;
    video_in = lvl;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pix_en = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_outputs", int'({pixel_valid, pixel_x, pixel_y, pixel_level, line_start, frame_start, locked, sync_error}), 0);
`ifdef VIDEO_DECODER_STATS_EN
    chk("reset_stats", int'({frame_count, last_lines}), 0);
`endif
    synced = 1'b0;
    lock_exp = 1'b0;
    fc_exp = 0;
    ll_exp = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic send_vsync(input int len);
    repeat (len) put(2'd0);
    fs_exp++;
    fc_exp = (fc_exp + 1) & 16'hffff;
    ll_exp = (synced && lines > V_BACK) ? lines - V_BACK : 0;
    if (synced && lines > V_BACK) begin
      if (lines - V_BACK == V_DISPLAY) lock_exp = 1'b1;
      else begin
        lock_exp = 1'b0;
        se_exp++;
      end
    end
    synced = 1'b1;
    lines = 0;
    repeat (10) put(2'($urandom_range(1, 3)));
  endtask
  task automatic send_line(input int slen, input int stall_at = -1, input int rst_at = -1);
    bit hs;
    int row;
    logic [1:0] lvl;
    repeat (slen) put(2'd0);
    hs = slen >= HSYNC_MIN && slen <= HSYNC_MAX;
    if (hs) begin
      ls_exp++;
      lines++;
    end else begin
      se_exp++;
      lock_exp = 1'b0;
      synced = 1'b0;
    end
    for (int i = 0; i < LINE_NS; i++) begin
      lvl = 2'($urandom_range(1, 3));
      if (i == stall_at) idle(50);
      if (i == rst_at) do_reset();
      row = lines - V_BACK - 1;
      if (hs && synced && lines > V_BACK && row < V_DISPLAY && i >= H_BACK && i < H_BACK + H_DISPLAY)
        exp_q.push_back({9'(i - H_BACK), 9'(row), lvl});
      put(lvl);
    end
  endtask
  task automatic frame(input int nlines, input int vlen);
    for (int l = 0; l < nlines; l++) send_line(6);
    send_vsync(vlen);
  endtask
  task automatic checkpoint(input string tag);
    idle(3);
    chk({tag, "_pixels_left"}, exp_q.size(), 0);
    chk({tag, "_line_starts"}, ls_cnt, ls_exp);
    chk({tag, "_frame_starts"}, fs_cnt, fs_exp);
    chk({tag, "_sync_errors"}, se_cnt, se_exp);
    chk({tag, "_locked"}, int'(locked), int'(lock_exp));
`ifdef VIDEO_DECODER_STATS_EN
    chk({tag, "_frame_count"}, int'(frame_count), fc_exp);
    chk({tag, "_last_lines"}, int'(last_lines), ll_exp);
`endif
  endtask
  initial begin
    int bl[4] = '{3, 9, 29, 20};
    reset = 1'b1;
    pix_en = 1'b0;
    video_in = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'({pixel_valid, pixel_x, pixel_y, pixel_level, line_start, frame_start, locked, sync_error}), 0);
    @(negedge clk);
    reset = 1'b0;
    send_vsync(40);
    checkpoint("first_vsync");
    frame(FULL, 40);
    checkpoint("frame1");
    for (int l = 0; l < FULL; l++) send_line(l % 2 ? HSYNC_MAX : HSYNC_MIN);
    send_vsync(VSYNC_MIN);
    checkpoint("sync_bounds");
    for (int l = 0; l < FULL; l++) send_line(6, l == V_BACK + 2 ? 12 : -1);
    send_vsync(40);
    checkpoint("pix_en_stall");
    frame(V_BACK + V_DISPLAY / 2, 40);
    checkpoint("short_frame");
    frame(FULL, 40);
    checkpoint("recover_short");
    frame(FULL + 2, 40);
    checkpoint("long_frame");
    frame(FULL, 40);
    checkpoint("recover_long");
    foreach (bl[k]) begin
      for (int l = 0; l < V_BACK + 4; l++) send_line(6);
      send_line(bl[k]);
      repeat (2) send_line(6);
      send_vsync(40);
      checkpoint("bad_run");
      frame(FULL, 40);
      checkpoint("recover_bad");
    end
    for (int l = 0; l < FULL; l++) send_line(6, -1, l == V_BACK + 3 ? 10 : -1);
    send_vsync(40);
    checkpoint("after_reset");
    frame(FULL, 40);
    checkpoint("relock");
    repeat (2) frame(FULL, 40);
    checkpoint("three_good");
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
